// File: rtl/tile_map_ram.sv
// Writable 30x40 tile map, copied row by row from the level ROM on request.
// Define TILE_MAP_HIT_COUNT_EN to count destroyed bricks.
module tile_map_ram #(
  parameter int ROWS   = 30,
  parameter int COLS   = 40,
  parameter int ROM_AW = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [COLS-1:0]   rom_data,
  output logic              loading,
  output logic              load_done,
  output logic              map_ready,
  input  logic [4:0]        rd_row,
  input  logic [5:0]        rd_col,
  output logic              rd_tile,
  input  logic [4:0]        chk_row,
  input  logic [5:0]        chk_col,
  output logic              chk_solid,
  input  logic              hit_valid,
  input  logic [4:0]        hit_row,
  input  logic [5:0]        hit_col,
  output logic [10:0]       bricks_destroyed
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } state_t;

  localparam logic [4:0]        NROW = 5'(ROWS);
  localparam logic [5:0]        NCOL = 6'(COLS);
  localparam logic [5:0]        MSB  = 6'(COLS - 1);
  localparam logic [ROM_AW-1:0] LAST = ROM_AW'(ROWS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ROM_AW-1:0] cnt_q;
  logic [COLS-1:0]   map_q [ROWS];
  logic              done_q;
  logic              rd_q;
  logic              chk_q;

  logic            go;
  logic            last;
  logic            hit_ok;
  logic            rd_in;
  logic            chk_in;
  logic            hit_in;
  logic [COLS-1:0] rd_line;
  logic [COLS-1:0] chk_line;
  logic [5:0]      rd_bit;
  logic [5:0]      chk_bit;
  logic [5:0]      hit_bit;

  assign last    = (cnt_q == LAST);
  assign go      = load_start && (state_q != LOAD);

  // column 0 is the ROM word MSB
  assign rd_bit  = MSB - rd_col;
  assign chk_bit = MSB - chk_col;
  assign hit_bit = MSB - hit_col;

  assign rd_in   = (rd_row < NROW) && (rd_col < NCOL);
  assign chk_in  = (chk_row < NROW) && (chk_col < NCOL);
  assign hit_in  = (hit_row < NROW) && (hit_col < NCOL);

  assign rd_line  = map_q[rd_row];
  assign chk_line = map_q[chk_row];

  // a reload request wins over a same-cycle hit
  assign hit_ok = hit_valid && hit_in
               && (state_q == READY) && !load_start;

  assign rom_addr  = cnt_q;
  assign loading   = (state_q == LOAD);
  assign map_ready = (state_q == READY);
  assign load_done = done_q;
  assign rd_tile   = rd_q;
  assign chk_solid = chk_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD:    if (last) state_d = READY;
      READY:   if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == LOAD) && last;
      if (go)
        cnt_q <= '0;
      else if (state_q == LOAD)
        cnt_q <= last ? '0 : cnt_q + 1'b1;
      rd_q  <= map_ready && rd_in && rd_line[rd_bit];
      chk_q <= !map_ready || !chk_in || chk_line[chk_bit];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++)
        map_q[r] <= '0;
    end else if (state_q == LOAD) begin
      map_q[cnt_q[4:0]] <= rom_data;
    end else if (hit_ok) begin
      map_q[hit_row][hit_bit] <= 1'b0;
    end
  end

`ifdef TILE_MAP_HIT_COUNT_EN
  logic [COLS-1:0] hit_line;
  logic [10:0]     hits_q;

  assign hit_line = map_q[hit_row];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hits_q <= '0;
    else if (go)
      hits_q <= '0;
    else if (hit_ok && hit_line[hit_bit] && (hits_q != '1))
      hits_q <= hits_q + 1'b1;
  end

  assign bricks_destroyed = hits_q;
`else
  assign bricks_destroyed = '0;
`endif

endmodule
